maze_dfs_walker: RTL and testbench
==================================

// Module: maze_dfs_walker
// PURPOSE
//  Parametrised depth-first maze walker for an N x N grid (N = 2**COORD_W). Starts at cell 0 and
//  searches for a runtime-selected destination. Drives an external 1-bit cell memory (1 = wall/visited)
//  and an external location stack for backtracking. Adds bounds-checked neighbours, stack-overflow
//  detection, a step-limit timeout and a coded fail reason. Sits between top-level start/status and the maze RAM/stack.
// PARAMETERS
//  COORD_W    4     bits per coordinate; loc = {row,col}, LOC_W = 2*COORD_W
//  MAX_STEPS  1024  forward moves + backtracks allowed before timeout (>=2)
//  STEP_W     11    step counter width; must hold MAX_STEPS
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  start      in   1       launch search; sampled in IDLE/DONE/FAIL only
//  dst_loc    in   LOC_W   destination {row,col}; captured when start is accepted
//  mem_rd_en  out  1       cell read strobe; mem_rdata valid exactly 1 cycle later
//  mem_wr_en  out  1       cell write strobe; mem_wdata written to mem_addr
//  mem_addr   out  LOC_W   cell address
//  mem_wdata  out  1       always 1 (mark visited)
//  mem_rdata  in   1       1 = blocked or visited
//  stk_push   out  1       push stk_din this edge
//  stk_pop    out  1       pop this edge
//  stk_din    out  LOC_W   location to push (= cur_loc)
//  stk_dout   in   LOC_W   top of stack, combinational, valid while !stk_empty
//  stk_empty  in   1       stack empty
//  stk_full   in   1       stack full
//  cur_loc    out  LOC_W   current cell
//  step_cnt   out  STEP_W  moves + backtracks so far
//  busy       out  1       search in progress
//  done       out  1       level; held in DONE
//  fail       out  1       level; held in FAIL
//  fail_code  out  2       01 no path, 10 stack overflow, 11 timeout; 00 otherwise
// BEHAVIOUR
//  - Reset: state IDLE; cur_loc=0, step_cnt=0, dir=0, dst=0; all strobes, busy, done, fail, fail_code = 0.
//    Reset mid-search aborts immediately; memory and stack contents are not touched.
//  - dir order 0 up(row-1), 1 right(col+1), 2 down(row+1), 3 left(col-1); 3-bit dir_cnt, 4 = exhausted.
//  - Neighbour out of grid (row/col would wrap) is skipped in PICK with no memory read.
//  - All strobes are combinational decodes of state; at most one of push/pop, one of rd/wr per cycle.
//  - States:
//    IDLE : start -> MARK; cur_loc<=0, step_cnt<=0, dir<=0, dst<=dst_loc, fail_code<=0.
//    MARK : mem_wr_en=1, mem_addr=cur_loc. cur_loc==dst -> DONE else PICK.
//    PICK : dir==4 -> BACK; neighbour OOB -> dir<=dir+1, stay; else -> READ.
//    READ : mem_rd_en=1, mem_addr=neighbour -> CHECK.
//    CHECK: mem_rdata=1 -> dir<=dir+1, PICK. Else: step_cnt==MAX_STEPS -> FAIL(11);
//           stk_full -> FAIL(10); else stk_push=1, stk_din=cur_loc, cur_loc<=neighbour,
//           step_cnt<=step_cnt+1, dir<=0 -> MARK.
//    BACK : stk_empty -> FAIL(01); step_cnt==MAX_STEPS -> FAIL(11); else stk_pop=1,
//           cur_loc<=stk_dout, step_cnt<=step_cnt+1, dir<=0 -> PICK (cell already marked).
//    DONE : done=1; start -> relaunch as IDLE.   FAIL: fail=1, fail_code held; start -> relaunch as IDLE.
//  - Priority in CHECK/BACK: timeout over overflow/no-path (empty checked first in BACK only).
//  - busy=1 in MARK..BACK. start while busy ignored. Dead-end cells stay marked (never re-entered).
//  - dst_loc==0: MARK of cell 0 -> DONE with step_cnt=0.
//  - Memory is not cleared by this block; walls preloaded, visited bits cleared externally between runs.
//  - Stack is not flushed; on DONE it holds the path cell 0..parent-of-dst.
// TESTING
//  1 COORD_W=2, empty grid, dst=0x33 -> done after 6 moves, step_cnt=6, cur_loc=0x33, stack depth 6.
//  2 Walls fully around dst 0x33 -> fail=1, fail_code=01, stk_empty, every reachable cell marked once.
//  3 Cell 0 at top-left: no mem_rd_en ever addresses a wrapped neighbour (up/left of row 0/col 0).
//  4 Stack depth 3, dst 0x33 on empty grid -> 4th push attempt gives fail_code=10, no push strobe.
//  5 MAX_STEPS=4, serpentine maze -> fail_code=11 with step_cnt=4; restart via start resets step_cnt=0.
//  6 rst asserted mid-READ -> all outputs 0 same cycle; new start after release runs normally.

Source files
------------

// File: rtl/maze_dfs_walker_if.sv
// Maze walker bus: cell memory port plus backtracking stack port.
interface maze_dfs_walker_if #(
    parameter int unsigned LOC_W = 8
);
    logic             mem_rd_en;
    logic             mem_wr_en;
    logic [LOC_W-1:0] mem_addr;
    logic             mem_wdata;
    logic             mem_rdata;
    logic             stk_push;
    logic             stk_pop;
    logic [LOC_W-1:0] stk_din;
    logic [LOC_W-1:0] stk_dout;
    logic             stk_empty;
    logic             stk_full;

    // Walker side
    modport master (
        output mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        input  mem_rdata,
        output stk_push, stk_pop, stk_din,
        input  stk_dout, stk_empty, stk_full
    );

    // Memory / stack side
    modport slave (
        input  mem_rd_en, mem_wr_en, mem_addr, mem_wdata,
        output mem_rdata,
        input  stk_push, stk_pop, stk_din,
        output stk_dout, stk_empty, stk_full
    );
endinterface

// File: rtl/maze_dfs_walker.sv
// Depth-first maze walker: marks cells visited, probes neighbours in
// up/right/down/left order, backtracks through an external stack.
module maze_dfs_walker #(
    parameter int unsigned COORD_W   = 4,
    parameter int unsigned MAX_STEPS = 1024,
    parameter int unsigned STEP_W    = 11
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_i,
    input  logic [2*COORD_W-1:0]   dst_loc_i,
    maze_dfs_walker_if.master      bus,
    output logic [2*COORD_W-1:0]   cur_loc_o,
    output logic [STEP_W-1:0]      step_cnt_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   fail_o,
    output logic [1:0]             fail_code_o
);
    localparam int unsigned        LOC_W     = 2 * COORD_W;
    localparam logic [COORD_W-1:0] COORD_MAX = {COORD_W{1'b1}};
    localparam logic [STEP_W-1:0]  STEP_LIM  = STEP_W'(MAX_STEPS);
    localparam logic [2:0]         DIR_END   = 3'd4;
    localparam logic [1:0]         FC_NOPATH = 2'b01;
    localparam logic [1:0]         FC_OVFL   = 2'b10;
    localparam logic [1:0]         FC_TMO    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_MARK, S_PICK, S_READ, S_CHECK, S_BACK, S_DONE, S_FAIL
    } state_e;

    state_e             state_q, state_d;
    logic [LOC_W-1:0]   cur_q, cur_d;
    logic [LOC_W-1:0]   dst_q, dst_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [2:0]         dir_q, dir_d;
    logic [1:0]         fc_q, fc_d;
    logic               busy_q, done_q, fail_q;

    logic [COORD_W-1:0] row, col, nb_row, nb_col;
    logic [LOC_W-1:0]   nb_loc;
    logic               nb_oob;

    logic               rd_en, wr_en, push, pop;
    logic [LOC_W-1:0]   addr;

    assign row    = cur_q[LOC_W-1:COORD_W];
    assign col    = cur_q[COORD_W-1:0];
    assign nb_loc = {nb_row, nb_col};

    // Neighbour in the current direction and whether it falls off the grid
    always_comb begin
        nb_row = row;
        nb_col = col;
        nb_oob = 1'b1;
        case (dir_q)
            3'd0: begin nb_oob = (row == '0);       nb_row = row - COORD_W'(1); end
            3'd1: begin nb_oob = (col == COORD_MAX); nb_col = col + COORD_W'(1); end
            3'd2: begin nb_oob = (row == COORD_MAX); nb_row = row + COORD_W'(1); end
            3'd3: begin nb_oob = (col == '0);       nb_col = col - COORD_W'(1); end
            default: nb_oob = 1'b1;
        endcase
    end

    // Next-state and strobe decode
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        dst_d   = dst_q;
        step_d  = step_q;
        dir_d   = dir_q;
        fc_d    = fc_q;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        push    = 1'b0;
        pop     = 1'b0;
        addr    = cur_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start_i) begin
                    state_d = S_MARK;
                    cur_d   = '0;
                    step_d  = '0;
                    dir_d   = '0;
                    dst_d   = dst_loc_i;
                    fc_d    = 2'b00;
                end
            end
            S_MARK: begin
                wr_en   = 1'b1;
                state_d = (cur_q == dst_q) ? S_DONE : S_PICK;
            end
            S_PICK: begin
                if (dir_q == DIR_END) begin
                    state_d = S_BACK;
                end else if (nb_oob) begin
                    dir_d = dir_q + 3'd1;
                end else begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                rd_en   = 1'b1;
                addr    = nb_loc;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.mem_rdata) begin
                    dir_d   = dir_q + 3'd1;
                    state_d = S_PICK;
                end else if (step_q == STEP_LIM) begin
                    fc_d    = FC_TMO;
                    state_d = S_FAIL;
                end else if (bus.stk_full) begin
                    fc_d    = FC_OVFL;
                    state_d = S_FAIL;
                end else begin
                    push    = 1'b1;
                    cur_d   = nb_loc;
                    step_d  = step_q + STEP_W'(1);
                    dir_d   = '0;
                    state_d = S_MARK;
                end
            end
            S_BACK: begin
                if (bus.stk_empty) begin
                    fc_d    = FC_NOPATH;
                    state_d = S_FAIL;
                end else if (step_q == STEP_LIM) begin
                    fc_d    = FC_TMO;
                    state_d = S_FAIL;
                end else begin
                    pop     = 1'b1;
                    cur_d   = bus.stk_dout;
                    step_d  = step_q + STEP_W'(1);
                    dir_d   = '0;
                    state_d = S_PICK;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; status flags track the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            dst_q   <= '0;
            step_q  <= '0;
            dir_q   <= '0;
            fc_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            dst_q   <= dst_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
            fc_q    <= fc_d;
            busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE) && (state_d != S_FAIL);
            done_q  <= (state_d == S_DONE);
            fail_q  <= (state_d == S_FAIL);
        end
    end

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_wr_en = wr_en;
    assign bus.mem_addr  = addr;
    assign bus.mem_wdata = 1'b1;
    assign bus.stk_push  = push;
    assign bus.stk_pop   = pop;
    assign bus.stk_din   = cur_q;

    assign cur_loc_o   = cur_q;
    assign step_cnt_o  = step_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_code_o = fc_q;
endmodule

// File: tb/tb_maze_dfs_walker.sv
// Directed bench for maze_dfs_walker on a 4x4 grid with behavioural memory/stack.
module tb_maze_dfs_walker;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [3:0]  dst0 = '0, dst1 = '0;
    logic [3:0]  cur0, cur1;
    logic [10:0] step0;
    logic [2:0]  step1;
    logic        busy0, done0, fail0, busy1, done1, fail1;
    logic [1:0]  fc0, fc1;

    int n_assert = 0;
    int n_fail   = 0;

    maze_dfs_walker_if #(.LOC_W(4)) bus0 ();
    maze_dfs_walker_if #(.LOC_W(4)) bus1 ();

    maze_dfs_walker #(.COORD_W(2), .MAX_STEPS(1024), .STEP_W(11)) dut0 (
        .clk(clk), .rst(rst), .start_i(start0), .dst_loc_i(dst0), .bus(bus0),
        .cur_loc_o(cur0), .step_cnt_o(step0), .busy_o(busy0), .done_o(done0),
        .fail_o(fail0), .fail_code_o(fc0)
    );

    maze_dfs_walker #(.COORD_W(2), .MAX_STEPS(4), .STEP_W(3)) dut1 (
        .clk(clk), .rst(rst), .start_i(start1), .dst_loc_i(dst1), .bus(bus1),
        .cur_loc_o(cur1), .step_cnt_o(step1), .busy_o(busy1), .done_o(done1),
        .fail_o(fail1), .fail_code_o(fc1)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] loc(input int r, input int c);
        logic [1:0] rr, cc;
        rr = 2'(r);
        cc = 2'(c);
        return {rr, cc};
    endfunction

    function automatic bit adjacent(input logic [3:0] a, input logic [3:0] b);
        int dr, dc;
        dr = int'(a[3:2]) - int'(b[3:2]);
        dc = int'(a[1:0]) - int'(b[1:0]);
        if (dr < 0) dr = -dr;
        if (dc < 0) dc = -dc;
        return (dr + dc) == 1;
    endfunction

    // Instance 0 environment: memory, stack and bus monitors
    logic [15:0] mem0, walls0 = '0;
    logic        ld0 = 1'b0, rdata0_q;
    int          cap0 = 16;
    logic [3:0]  stk0 [16];
    int          sp0, wr_cnt0 [16];
    int          rd_cnt0, bad_rd0, bad_push0, push_cnt0;

    assign bus0.mem_rdata = rdata0_q;
    assign bus0.stk_dout  = (sp0 > 0) ? stk0[4'(sp0 - 1)] : 4'h0;
    assign bus0.stk_empty = (sp0 == 0);
    assign bus0.stk_full  = (sp0 >= cap0);

    always @(posedge clk) begin
        if (ld0) begin
            mem0 <= walls0; sp0 <= 0; rdata0_q <= 1'b0;
            rd_cnt0 <= 0; bad_rd0 <= 0; bad_push0 <= 0; push_cnt0 <= 0;
            for (int i = 0; i < 16; i++) wr_cnt0[i] <= 0;
        end else begin
            if (bus0.mem_wr_en) begin
                mem0[bus0.mem_addr]    <= bus0.mem_wdata;
                wr_cnt0[bus0.mem_addr] <= wr_cnt0[bus0.mem_addr] + 1;
            end
            if (bus0.mem_rd_en) begin
                rdata0_q <= mem0[bus0.mem_addr];
                rd_cnt0  <= rd_cnt0 + 1;
                if (!adjacent(cur0, bus0.mem_addr)) bad_rd0 <= bad_rd0 + 1;
            end
            if (bus0.stk_push) begin
                if (sp0 >= cap0) bad_push0 <= bad_push0 + 1;
                else begin
                    stk0[4'(sp0)] <= bus0.stk_din;
                    sp0 <= sp0 + 1;
                    push_cnt0 <= push_cnt0 + 1;
                end
            end
            if (bus0.stk_pop && sp0 > 0) sp0 <= sp0 - 1;
        end
    end

    // Instance 1 environment
    logic [15:0] mem1, walls1 = '0;
    logic        ld1 = 1'b0, rdata1_q;
    logic [3:0]  stk1 [16];
    int          sp1;

    assign bus1.mem_rdata = rdata1_q;
    assign bus1.stk_dout  = (sp1 > 0) ? stk1[4'(sp1 - 1)] : 4'h0;
    assign bus1.stk_empty = (sp1 == 0);
    assign bus1.stk_full  = (sp1 >= 16);

    always @(posedge clk) begin
        if (ld1) begin
            mem1 <= walls1; sp1 <= 0; rdata1_q <= 1'b0;
        end else begin
            if (bus1.mem_wr_en) mem1[bus1.mem_addr] <= 1'b1;
            if (bus1.mem_rd_en) rdata1_q <= mem1[bus1.mem_addr];
            if (bus1.stk_push && sp1 < 16) begin
                stk1[4'(sp1)] <= bus1.stk_din;
                sp1 <= sp1 + 1;
            end
            if (bus1.stk_pop && sp1 > 0) sp1 <= sp1 - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load0(input logic [15:0] w, input int cap);
        @(negedge clk); walls0 = w; cap0 = cap; ld0 = 1'b1;
        @(negedge clk); ld0 = 1'b0;
    endtask

    task automatic load1(input logic [15:0] w);
        @(negedge clk); walls1 = w; ld1 = 1'b1;
        @(negedge clk); ld1 = 1'b0;
    endtask

    task automatic go0(input logic [3:0] d);
        @(negedge clk); dst0 = d; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
    endtask

    task automatic go1(input logic [3:0] d);
        @(negedge clk); dst1 = d; start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
    endtask

    task automatic wait0(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (done0 || fail0) ok = 1'b1;
            else @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait1(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            if (done1 || fail1) ok = 1'b1;
            else @(negedge clk);
        end
        chk(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        logic [15:0] w;
        int          bad_cells;
        bit          seen;

        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_outs", 32'({cur0, step0, busy0, done0, fail0, fc0}), 32'd0);
        chk("rst_strobes", 32'({bus0.mem_rd_en, bus0.mem_wr_en, bus0.stk_push, bus0.stk_pop}), 32'd0);
        chk("rst_wdata", 32'(bus0.mem_wdata), 32'd1);

        // Destination is the start cell
        load0(16'h0000, 16);
        go0(4'h0);
        wait0("dst0_end");
        chk("dst0_status", 32'({done0, fail0, busy0}), 32'b100);
        chk("dst0_step", 32'(step0), 32'd0);
        chk("dst0_push", 32'(push_cnt0), 32'd0);

        // Empty grid to far corner
        load0(16'h0000, 16);
        go0(loc(3, 3));
        wait0("open_end");
        chk("open_done", 32'({done0, fail0, fc0}), 32'b1000);
        chk("open_step", 32'(step0), 32'd6);
        chk("open_cur", 32'(cur0), 32'(loc(3, 3)));
        chk("open_depth", 32'(sp0), 32'd6);
        chk("open_top", 32'(bus0.stk_dout), 32'(loc(2, 3)));
        chk("open_rd_adj", 32'(bad_rd0), 32'd0);

        // Destination walled in: exhaustive search then no-path
        w = '0;
        w[loc(2, 3)] = 1'b1;
        w[loc(3, 2)] = 1'b1;
        load0(w, 16);
        go0(loc(3, 3));
        wait0("walled_end");
        chk("walled_fail", 32'({done0, fail0, fc0}), 32'b0101);
        chk("walled_step", 32'(step0), 32'd24);
        chk("walled_empty", 32'(sp0), 32'd0);
        chk("walled_cur", 32'(cur0), 32'(loc(0, 0)));
        bad_cells = 0;
        for (int i = 0; i < 16; i++) begin
            if (w[i] || i == 15) begin
                if (wr_cnt0[i] != 0) bad_cells++;
            end else if (wr_cnt0[i] != 1) bad_cells++;
        end
        chk("walled_marks", 32'(bad_cells), 32'd0);
        chk("walled_rd_adj", 32'(bad_rd0), 32'd0);
        chk("walled_rd_some", 32'(rd_cnt0 > 20), 32'd1);

        // Stack of depth 3 overflows on fourth push
        load0(16'h0000, 3);
        go0(loc(3, 3));
        wait0("ovfl_end");
        chk("ovfl_fail", 32'({done0, fail0, fc0}), 32'b0110);
        chk("ovfl_push", 32'(push_cnt0), 32'd3);
        chk("ovfl_nopush", 32'(bad_push0), 32'd0);
        chk("ovfl_step", 32'(step0), 32'd3);
        chk("ovfl_cur", 32'(cur0), 32'(loc(0, 3)));

        // Timeout with MAX_STEPS=4 in a serpentine maze, then relaunch
        w = '0;
        w[loc(1, 0)] = 1'b1; w[loc(1, 1)] = 1'b1; w[loc(1, 2)] = 1'b1;
        w[loc(2, 1)] = 1'b1; w[loc(2, 2)] = 1'b1; w[loc(2, 3)] = 1'b1;
        load1(w);
        go1(loc(3, 0));
        wait1("tmo_end");
        chk("tmo_fail", 32'({done1, fail1, fc1}), 32'b0111);
        chk("tmo_step", 32'(step1), 32'd4);
        chk("tmo_cur", 32'(cur1), 32'(loc(1, 3)));
        load1(w);
        go1(loc(3, 0));
        chk("tmo_relaunch", 32'({step1, busy1, fail1, fc1}), 32'b000_1_0_00);
        wait1("tmo_end2");
        chk("tmo_fail2", 32'({fail1, fc1, step1}), 32'b1_11_100);

        // Reset during a READ cycle, then a clean rerun
        load0(16'h0000, 16);
        go0(loc(3, 3));
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            if (bus0.mem_rd_en && step0 >= 11'd2) seen = 1'b1;
            else @(negedge clk);
        end
        chk("midrd_seen", 32'(seen), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrd_outs", 32'({cur0, step0, busy0, done0, fail0, fc0}), 32'd0);
        chk("midrd_strobes", 32'({bus0.mem_rd_en, bus0.mem_wr_en, bus0.stk_push, bus0.stk_pop}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        load0(16'h0000, 16);
        go0(loc(3, 3));
        wait0("rerun_end");
        chk("rerun_done", 32'({done0, fail0, step0}), {19'd0, 2'b10, 11'd6});
        chk("rerun_depth", 32'(sp0), 32'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
